button_menu: RTL and testbench

- Parametrised successor to the five-button front-panel controller.
- Synchronises and debounces the L/R/U/D/S push-buttons, then edge-detects them.
- L/R move a selection cursor over NSEL effect slots; U/D step the selected slot's OPT_W-bit value, with auto-repeat while held; S toggles the selected slot's enable.
- Outputs feed the effect-pipeline configuration registers directly.

---
 rtl/button_menu.sv | 123 ++++++++++++
 tb/tb_button_menu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_menu.sv
// Five-button front-panel menu: synchronise, debounce and edge-detect L/R/U/D/S,
// then move a cursor over NSEL slots and step/toggle the selected slot.
module button_menu #(
    parameter int NSEL      = 4,
    parameter int OPT_W     = 2,
    parameter int DB_CYCLES = 500000,
    parameter int REP_DLY   = 25000000,
    parameter int REP_RATE  = 5000000,
    parameter int WRAP      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btnL,
    input  logic                     btnR,
    input  logic                     btnU,
    input  logic                     btnD,
    input  logic                     btnS,
    output logic [NSEL*OPT_W-1:0]    options,
    output logic [NSEL-1:0]          en,
    output logic [$clog2(NSEL)-1:0]  sel,
    output logic                     evt
);

    localparam int SEL_W   = $clog2(NSEL);
    localparam int DB_W    = $clog2(DB_CYCLES);
    localparam int REP_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0] DLY_LOAD  = REP_W'(REP_DLY - 1);
    localparam logic [REP_W-1:0] RATE_LOAD = REP_W'(REP_RATE - 1);
    localparam logic [OPT_W-1:0] OPT_MAX   = '1;

    // Bit order everywhere: 0=L, 1=R, 2=U, 3=D, 4=S
    logic [4:0]       btnRaw;
    logic [4:0]       sync1, sync2;
    logic [4:0]       dbLevel, dbPrev;
    logic [4:0]       press, pulse;
    logic [DB_W-1:0]  dbCnt [5];
    logic [REP_W-1:0] repCnt [2];
    logic [1:0]       repFire;

    assign btnRaw = {btnS, btnD, btnU, btnR, btnL};
    assign press  = dbLevel & ~dbPrev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            dbLevel <= '0;
            dbPrev  <= '0;
            for (int i = 0; i < 5; i++) dbCnt[i] <= '0;
        end else begin
            sync1  <= btnRaw;
            sync2  <= sync1;
            dbPrev <= dbLevel;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == dbLevel[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    dbLevel[i] <= sync2[i];
                    dbCnt[i]   <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat down-counters for U (0) and D (1); loaded on the press, fire at zero.
    always_comb begin
        repFire = '0;
        for (int j = 0; j < 2; j++)
            repFire[j] = dbLevel[j+2] & dbPrev[j+2] & (repCnt[j] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) repCnt[j] <= '0;
            pulse <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!dbLevel[j+2])        repCnt[j] <= '0;
                else if (press[j+2])      repCnt[j] <= DLY_LOAD;
                else if (repFire[j])      repCnt[j] <= RATE_LOAD;
                else if (repCnt[j] != '0) repCnt[j] <= repCnt[j] - 1'b1;
            end
            pulse <= press | {1'b0, repFire, 2'b00};
        end
    end

    logic             pL, pR, pU, pD, pS;
    logic [OPT_W-1:0] curVal, nextVal;

    assign {pS, pD, pU, pR, pL} = pulse;
    assign curVal = options[sel*OPT_W +: OPT_W];

    always_comb begin
        nextVal = curVal;
        if (pU && !pD) begin
            if (WRAP != 0 || curVal != OPT_MAX) nextVal = curVal + 1'b1;
        end else if (pD && !pU) begin
            if (WRAP != 0 || curVal != '0) nextVal = curVal - 1'b1;
        end
    end

    // Value/enable actions address the pre-update sel; the cursor moves on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            options <= '0;
            en      <= '0;
            sel     <= '0;
            evt     <= 1'b0;
        end else begin
            evt <= (pL ^ pR) | (pU ^ pD) | pS;
            if (pL && !pR)      sel <= sel - SEL_W'(1);
            else if (pR && !pL) sel <= sel + SEL_W'(1);
            if (pU ^ pD) options[sel*OPT_W +: OPT_W] <= nextVal;
            if (pS)      en[sel] <= ~en[sel];
        end
    end

endmodule

// File: tb/tb_button_menu.sv
// Randomised bench for button_menu: a WRAP=1 and a WRAP=0 instance share stimulus and
// are compared every cycle against a window/time-offset reference model.
module tb_button_menu;

    localparam int NSEL  = 4;
    localparam int OPT_W = 2;
    localparam int DB    = 4;
    localparam int RD    = 20;
    localparam int RR    = 5;
    localparam int MAXV  = 3;

    localparam logic [4:0] B_L = 5'b00001;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_U = 5'b00100;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_S = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnS = 1'b0;

    logic [7:0] optionsW, optionsS;
    logic [3:0] enW, enS;
    logic [1:0] selW, selS;
    logic       evtW, evtS;

    always #5 clk = ~clk;

    button_menu #(.NSEL(NSEL), .OPT_W(OPT_W), .DB_CYCLES(DB), .REP_DLY(RD),
                  .REP_RATE(RR), .WRAP(1)) dutWrap (
        .clk(clk), .rst(rst), .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
        .btnS(btnS), .options(optionsW), .en(enW), .sel(selW), .evt(evtW));

    button_menu #(.NSEL(NSEL), .OPT_W(OPT_W), .DB_CYCLES(DB), .REP_DLY(RD),
                  .REP_RATE(RR), .WRAP(0)) dutSat (
        .clk(clk), .rst(rst), .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
        .btnS(btnS), .options(optionsS), .en(enS), .sel(selS), .evt(evtS));

    int nVec  = 0;
    int nFail = 0;

    task automatic checkVal(input string tag, input int got, input int exp);
        nVec++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: index 0 = wrapping instance, 1 = saturating instance
    int         mOpt [2];
    int         mEn  [2];
    int         mSel [2];
    int         mEvt [2];
    logic [4:0] mRaw1, mRaw2;
    logic [4:0] mDb, mDbOld;
    int         mRise [5];
    logic [4:0] sHist [$];
    int         edgeNo = 0;

    function automatic void modelReset();
        for (int i = 0; i < 2; i++) begin
            mOpt[i] = 0; mEn[i] = 0; mSel[i] = 0; mEvt[i] = 0;
        end
        mRaw1 = '0; mRaw2 = '0; mDb = '0; mDbOld = '0;
        for (int b = 0; b < 5; b++) mRise[b] = 0;
        sHist.delete();
        for (int k = 0; k < DB; k++) sHist.push_back(5'b0);
    endfunction

    function automatic void modelStep(input logic [4:0] raw);
        logic [4:0] act;
        int d, s, v, sh;
        bit allDiff;
        act = '0;
        // A press acts 2 edges after debounced acceptance; U/D repeat at REP_DLY + k*REP_RATE.
        for (int b = 0; b < 5; b++) begin
            if (mDbOld[b]) begin
                d = edgeNo - mRise[b] - 2;
                if (d == 0) act[b] = 1'b1;
                else if ((b == 2 || b == 3) && d >= RD && ((d - RD) % RR) == 0) act[b] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            s = mSel[i];
            mEvt[i] = 0;
            if (act[0] != act[1]) begin
                mEvt[i] = 1;
                mSel[i] = act[0] ? (s + NSEL - 1) % NSEL : (s + 1) % NSEL;
            end
            if (act[2] != act[3]) begin
                mEvt[i] = 1;
                sh = s * OPT_W;
                v  = (mOpt[i] >> sh) & MAXV;
                if (act[2]) v = (v == MAXV) ? ((i == 0) ? 0 : MAXV) : v + 1;
                else        v = (v == 0)    ? ((i == 0) ? MAXV : 0) : v - 1;
                mOpt[i] = (mOpt[i] & ~(MAXV << sh)) | (v << sh);
            end
            if (act[4]) begin
                mEvt[i] = 1;
                mEn[i]  = mEn[i] ^ (1 << s);
            end
        end
        mDbOld = mDb;
        sHist.push_back(mRaw2);
        if (sHist.size() > DB) void'(sHist.pop_front());
        for (int b = 0; b < 5; b++) begin
            allDiff = 1'b1;
            foreach (sHist[k]) if (sHist[k][b] == mDb[b]) allDiff = 1'b0;
            if (allDiff) begin
                mDb[b] = ~mDb[b];
                if (mDb[b]) mRise[b] = edgeNo;
            end
        end
        mRaw2 = mRaw1;
        mRaw1 = raw;
        edgeNo++;
    endfunction

    task automatic checkAll();
        checkVal("optionsW", 32'(optionsW), mOpt[0]);
        checkVal("enW",      32'(enW),      mEn[0]);
        checkVal("selW",     32'(selW),     mSel[0]);
        checkVal("evtW",     32'(evtW),     mEvt[0]);
        checkVal("optionsS", 32'(optionsS), mOpt[1]);
        checkVal("enS",      32'(enS),      mEn[1]);
        checkVal("selS",     32'(selS),     mSel[1]);
        checkVal("evtS",     32'(evtS),     mEvt[1]);
    endtask

    task automatic cycle(input logic [4:0] b, input logic r);
        @(negedge clk);
        {btnS, btnD, btnU, btnR, btnL} = b;
        if (r && !rst) begin
            #2 rst = 1'b1;
            #1 modelReset();
            checkAll();
        end else begin
            rst = r;
        end
        @(posedge clk);
        if (!rst) modelStep(b);
        #1 checkAll();
    endtask

    task automatic hold(input logic [4:0] b, input int n, input int gap);
        repeat (n) cycle(b, 1'b0);
        repeat (gap) cycle(5'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] mask;
        int dur;
        modelReset();
        repeat (3) cycle(5'b0, 1'b1);
        checkVal("rst_sel", 32'(selW), 0);
        checkVal("rst_opt", 32'(optionsW), 0);
        hold(5'b0, 3, 0);

        // debounce and cursor
        hold(B_R, 3, 10);
        checkVal("glitch_sel", 32'(selW), 0);
        hold(B_R, 10, 10);
        checkVal("press_sel", 32'(selW), 1);
        hold(B_L, 8, 8);
        hold(B_L, 8, 8);
        checkVal("wrap_l_sel", 32'(selW), 3);
        hold(B_R, 8, 8);
        hold(B_R, 8, 8);
        checkVal("rr_sel", 32'(selW), 1);
        hold(B_L | B_R, 8, 8);
        checkVal("lr_sel", 32'(selW), 1);

        // value stepping on slot 2
        hold(B_R, 8, 8);
        repeat (3) hold(B_U, 8, 8);
        checkVal("u3_optW", 32'(optionsW), 'h30);
        checkVal("u3_optS", 32'(optionsS), 'h30);
        hold(B_U, 8, 8);
        checkVal("u4_optW", 32'(optionsW), 'h00);
        checkVal("u4_optS", 32'(optionsS), 'h30);

        // simultaneous S+U+R on slot 1
        hold(B_L, 8, 8);
        hold(B_S | B_U | B_R, 8, 8);
        checkVal("sur_en",   32'(enW), 'b0010);
        checkVal("sur_sel",  32'(selW), 2);
        checkVal("sur_optW", 32'(optionsW), 'h04);
        checkVal("sur_optS", 32'(optionsS), 'h34);

        // auto-repeat on U, single step on held L
        hold(B_U, 60, 10);
        hold(B_L, 60, 10);
        checkVal("hold_l_sel", 32'(selW), 1);

        // reset while U held, then U held through release
        hold(B_U, 30, 0);
        repeat (3) cycle(B_U, 1'b1);
        checkVal("midrst_opt", 32'(optionsW), 0);
        hold(B_U, 20, 10);
        checkVal("relrst_optW", 32'(optionsW), 1);
        checkVal("relrst_optS", 32'(optionsS), 1);

        // random phases
        for (int p = 0; p < 120; p++) begin
            if ($urandom_range(0, 9) < 6) mask = 5'b1 << $urandom_range(0, 4);
            else                          mask = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       dur = $urandom_range(1, 3);
                1:       dur = $urandom_range(5, 12);
                default: dur = $urandom_range(24, 45);
            endcase
            if ($urandom_range(0, 19) == 0) begin
                hold(mask, dur / 2 + 1, 0);
                repeat (2) cycle(mask, 1'b1);
            end
            hold(mask, dur, $urandom_range(0, 8));
        end
        hold(5'b0, 0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
